// File: rtl/fidget_pkg.sv
// Shared types and constants for the memory hex-dump engine:
// FSM state encoding, ASCII punctuation and hex-digit bases.
package fidget_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_COLON  = 4'd2,
    ST_READ   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_SPACE  = 4'd5,
    ST_HI     = 4'd6,
    ST_LO     = 4'd7,
    ST_CR     = 4'd8,
    ST_LF     = 4'd9,
    ST_FINISH = 4'd10
  } state_t;

  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

  // States that present one character on the transmit interface.
  function automatic logic is_char_state(input state_t s);
    case (s)
      ST_ADDR, ST_COLON, ST_SPACE, ST_HI, ST_LO, ST_CR, ST_LF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble-to-ASCII converter producing uppercase hex digits.
module hex_nibble_ascii
  import fidget_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASC_ZERO + {4'h0, i_nibble};
    end else begin
      o_ascii = ASC_A + {4'h0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/mem_hex_dump.sv
// Reads a byte range from memory and streams it as ASCII hex-dump lines
// ("AAAA: BB BB ..\r\n") through a valid/ready character interface.
module mem_hex_dump
  import fidget_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16
)
(
  input  logic        comm_clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [7:0] LINE_FULL = 8'(BYTES_PER_LINE);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_line_addr;
  logic [15:0] r_remain;
  logic [7:0]  r_line_cnt;
  logic [7:0]  r_byte;
  logic [1:0]  r_digit;

  logic        r_busy;
  logic        r_done;
  logic        r_mem_rd;
  logic [15:0] r_mem_addr;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;

  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_mem_rd_nxt;
  logic [15:0] w_mem_addr_nxt;
  logic        w_tx_valid_nxt;
  logic [7:0]  w_tx_data_nxt;

  logic        w_fire;
  logic        w_more;
  logic [3:0]  w_nibble;
  logic [7:0]  w_hex;
  logic [7:0]  w_char;

  assign w_fire = r_tx_valid & tx_ready & is_char_state(r_state);
  assign w_more = (r_remain != 16'd0) && (r_line_cnt != LINE_FULL);

  // One converter serves both the address digits and the data digits.
  always_comb begin
    w_nibble = 4'h0;
    case (r_state)
      ST_HI:   w_nibble = r_byte[7:4];
      ST_LO:   w_nibble = r_byte[3:0];
      default: begin
        case (r_digit)
          2'd0:    w_nibble = r_line_addr[15:12];
          2'd1:    w_nibble = r_line_addr[11:8];
          2'd2:    w_nibble = r_line_addr[7:4];
          default: w_nibble = r_line_addr[3:0];
        endcase
      end
    endcase
  end

  hex_nibble_ascii u_hex (
    .i_nibble (w_nibble),
    .o_ascii  (w_hex)
  );

  always_comb begin
    w_char = 8'h00;
    case (r_state)
      ST_ADDR, ST_HI, ST_LO: w_char = w_hex;
      ST_COLON:              w_char = ASC_COLON;
      ST_SPACE:              w_char = ASC_SPACE;
      ST_CR:                 w_char = ASC_CR;
      ST_LF:                 w_char = ASC_LF;
      default:               w_char = 8'h00;
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (length != 16'd0) ? ST_ADDR : ST_FINISH;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (w_fire && (r_digit == 2'd3)) begin
          w_next = ST_COLON;
        end else begin
          w_next = ST_ADDR;
        end
      end
      ST_COLON, ST_LO: begin
        if (w_fire) begin
          w_next = w_more ? ST_READ : ST_CR;
        end else begin
          w_next = r_state;
        end
      end
      ST_READ:  w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_SPACE;
      ST_SPACE: w_next = w_fire ? ST_HI : ST_SPACE;
      ST_HI:    w_next = w_fire ? ST_LO : ST_HI;
      ST_CR:    w_next = w_fire ? ST_LF : ST_CR;
      ST_LF: begin
        if (w_fire) begin
          w_next = (r_remain != 16'd0) ? ST_ADDR : ST_FINISH;
        end else begin
          w_next = ST_LF;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // A character is loaded one cycle after entering its state and held until accepted.
  always_comb begin
    w_tx_valid_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    if (is_char_state(r_state)) begin
      if (!r_tx_valid) begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = w_char;
      end else if (tx_ready) begin
        w_tx_valid_nxt = 1'b0;
      end else begin
        w_tx_valid_nxt = 1'b1;
      end
    end else begin
      w_tx_valid_nxt = 1'b0;
    end
    w_mem_rd_nxt   = (w_next == ST_READ);
    w_mem_addr_nxt = (w_next == ST_READ) ? r_addr : r_mem_addr;
    w_busy_nxt     = (w_next != ST_IDLE);
    w_done_nxt     = (r_state == ST_FINISH);
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= 16'h0000;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // Address, byte and line bookkeeping; the address wraps naturally at 16 bits.
  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      r_addr      <= 16'h0000;
      r_line_addr <= 16'h0000;
      r_remain    <= 16'h0000;
      r_line_cnt  <= 8'h00;
      r_byte      <= 8'h00;
      r_digit     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_line_addr <= base_addr;
            r_remain    <= length;
            r_line_cnt  <= 8'h00;
            r_digit     <= 2'd0;
          end
        end
        ST_ADDR: begin
          if (w_fire) begin
            r_digit <= r_digit + 2'd1;
          end
        end
        ST_READ: begin
          r_addr     <= r_addr + 16'd1;
          r_remain   <= r_remain - 16'd1;
          r_line_cnt <= r_line_cnt + 8'd1;
        end
        ST_WAIT: r_byte <= mem_data;
        ST_LF: begin
          if (w_fire) begin
            r_line_addr <= r_addr;
            r_line_cnt  <= 8'h00;
            r_digit     <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_mem_hex_dump.sv
// Directed self-checking bench for mem_hex_dump with a byte-memory model
// and a character/handshake monitor.
module tb_mem_hex_dump;

  logic        comm_clock;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  mem_hex_dump #(.BYTES_PER_LINE(16)) dut (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial comm_clock = 1'b0;
  always #5 comm_clock = ~comm_clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] chars [$];
  logic [15:0] rd_addrs [$];
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int rd_cnt = 0;
  int stable_err = 0;
  int overlap_err = 0;
  int done_cyc = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  bit rnd_mode = 1'b0;
  bit ready_level = 1'b1;
  int last_acc = 0;
  int last_c0 = 0;
  int last_r0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory answers one cycle after a read strobe.
  always @(posedge comm_clock) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  always @(posedge comm_clock) begin
    #1;
    tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor samples on the falling edge, between DUT updates.
  always @(negedge comm_clock) begin
    if (reset_n && tx_valid && tx_ready) chars.push_back(tx_data);
    if (reset_n && prev_stall && (!tx_valid || tx_data != prev_data)) stable_err <= stable_err + 1;
    prev_stall <= reset_n && tx_valid && !tx_ready;
    prev_data  <= tx_data;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      rd_addrs.push_back(mem_addr);
    end
    if (mem_rd && tx_valid) overlap_err <= overlap_err + 1;
  end

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] len);
    @(posedge comm_clock); #1;
    base_addr = b;
    length    = len;
    start     = 1'b1;
    @(posedge comm_clock); #1;
    start     = 1'b0;
    base_addr = 16'h0000;
    length    = 16'h0000;
  endtask

  task automatic run_dump(input string tag, input logic [15:0] b, input logic [15:0] len,
                          input string exp, input bit poke, output int busy_seen);
    int d0, c0, r0, s0, o0, b0;
    logic [31:0] obs;
    d0 = done_cnt; c0 = chars.size(); r0 = rd_cnt; s0 = stable_err; o0 = overlap_err; b0 = busy_cnt;
    last_c0 = c0;
    last_r0 = rd_addrs.size();
    pulse_start(b, len);
    last_acc = cyc;
    if (poke) begin
      repeat (6) @(posedge comm_clock);
      pulse_start(16'hAAAA, 16'd5);
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge comm_clock);
    repeat (3) @(posedge comm_clock);
    #1;
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_nchars"}, 32'(chars.size() - c0), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      obs = (c0 + i < chars.size()) ? {24'h0, chars[c0 + i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_char%0d", tag, i), obs, {24'h0, exp[i]});
    end
    check({tag, "_reads"}, 32'(rd_cnt - r0), {16'h0, len});
    check({tag, "_stable"}, 32'(stable_err - s0), 32'd0);
    check({tag, "_rd_vs_tx"}, 32'(overlap_err - o0), 32'd0);
    check({tag, "_busy_end"}, {31'h0, busy}, 32'd0);
    busy_seen = busy_cnt - b0;
  endtask

  initial begin
    int bs;
    int d0, c0;
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    mem[16'h1000] = 8'hDE;
    mem[16'h1001] = 8'hAD;
    mem[16'h1002] = 8'h5A;
    reset_n = 1'b0; start = 1'b0; base_addr = 16'h0000; length = 16'h0000;
    repeat (3) @(posedge comm_clock);
    #1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("rst_tx_data", {24'h0, tx_data}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge comm_clock);

    run_dump("basic", 16'h1000, 16'd3, "1000: DE AD 5A\r\n", 1'b0, bs);

    run_dump("twoline", 16'h0010, 16'd17,
             "0010: 10 11 12 13 14 15 16 17 18 19 1A 1B 1C 1D 1E 1F\r\n0020: 20\r\n", 1'b1, bs);

    run_dump("len0", 16'h1234, 16'd0, "", 1'b0, bs);
    check("len0_busy_cycles", 32'(bs), 32'd1);
    check("len0_done_latency", 32'(done_cyc - last_acc), 32'd1);

    run_dump("wrap", 16'hFFFF, 16'd2, "FFFF: FF 00\r\n", 1'b0, bs);
    check("wrap_addr0", {16'h0, rd_addrs[last_r0]}, 32'h0000_FFFF);
    check("wrap_addr1", {16'h0, rd_addrs[last_r0 + 1]}, 32'h0000_0000);

    rnd_mode = 1'b1;
    run_dump("bp", 16'h1000, 16'd3, "1000: DE AD 5A\r\n", 1'b0, bs);
    rnd_mode = 1'b0;

    d0 = done_cnt; c0 = chars.size();
    pulse_start(16'h1000, 16'd3);
    for (int i = 0; i < 2000 && (chars.size() - c0) < 5; i++) @(negedge comm_clock);
    check("rst_mid_reached5", {31'h0, (chars.size() - c0) >= 5}, 32'd1);
    @(posedge comm_clock); #1;
    reset_n = 1'b0;
    @(posedge comm_clock); #1;
    reset_n = 1'b1;
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    check("rst_mid_tx_valid", {31'h0, tx_valid}, 32'd0);
    repeat (60) @(posedge comm_clock);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    run_dump("after_rst", 16'h1000, 16'd3, "1000: DE AD 5A\r\n", 1'b0, bs);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
